// File: rtl/period_meter.sv
// period_meter: times the period and high phase of a slow asynchronous signal
// in system-clock cycles. One result per rising-to-rising interval, plus a
// one-cycle timeout pulse when the signal stops toggling.
module period_meter #(
  parameter int          COUNT_WIDTH = 16,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_MAX = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   sig_in,
  output logic [COUNT_WIDTH-1:0] period,
  output logic [COUNT_WIDTH-1:0] high_time,
  output logic                   meas_valid,
  output logic                   timeout,
  output logic                   busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'(TIMEOUT_MAX);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d;
  logic                   rise, fall;
  logic [1:0]             state;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [COUNT_WIDTH-1:0] hi_cap;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
  assign busy = (state == ST_ARM) || (state == ST_MEAS);

  // Synchronizer chain plus one delay stage for edge detection; runs even
  // when disabled so edges are clean the moment enable returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d    <= s;
    end
  end

  // Measurement FSM: enable low wins over everything; a rise on the timeout
  // cycle is still a measurement because the rise branch is checked first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      hi_cap     <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      if (!enable) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        hi_cap <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt   <= '0;
            state <= ST_ARM;
          end
          ST_ARM: begin
            if (rise) begin
              cnt    <= CNT_ONE;
              hi_cap <= '0;
              state  <= ST_MEAS;
            end
          end
          ST_MEAS: begin
            if (rise) begin
              period     <= cnt;
              high_time  <= hi_cap;
              meas_valid <= 1'b1;
              cnt        <= CNT_ONE;
              hi_cap     <= '0;
            end else if (cnt == CNT_MAX) begin
              // stalled: drop the partial interval, results keep old values
              timeout <= 1'b1;
              cnt     <= '0;
              hi_cap  <= '0;
              state   <= ST_ARM;
            end else begin
              cnt <= cnt + CNT_ONE;
              if (fall) hi_cap <= cnt;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with TIMEOUT_MAX=20. A negedge monitor
// records result/timeout pulses; the main sequence compares against
// hand-computed values.
module tb_period_meter;

  localparam int CW   = 16;
  localparam int SYNC = 2;
  localparam int TMAX = 20;
  localparam int LAT  = SYNC + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          sig_in = 1'b0;
  logic [CW-1:0] period, high_time;
  logic          meas_valid, timeout, busy;

  period_meter #(.COUNT_WIDTH(CW), .SYNC_STAGES(SYNC), .TIMEOUT_MAX(TMAX)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .period(period), .high_time(high_time),
    .meas_valid(meas_valid), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // cycle counter and pulse monitor
  int cyc = 0;
  int mv_cnt = 0, to_cnt = 0, both_cnt = 0;
  int last_mv_cyc = 0, last_gap = 0, first_mv_cyc = 0, to_cyc = 0;
  int mark_cyc = 0;

  // count rising edges of clk
  always @(posedge clk) cyc <= cyc + 1;

  // sample DUT pulses away from the active edge
  always @(negedge clk) begin
    if (meas_valid) begin
      mv_cnt      <= mv_cnt + 1;
      last_gap    <= cyc - last_mv_cyc;
      last_mv_cyc <= cyc;
      if (first_mv_cyc <= mark_cyc) first_mv_cyc <= cyc;
    end
    if (timeout) begin
      to_cnt <= to_cnt + 1;
      to_cyc <= cyc;
    end
    if (meas_valid && timeout) both_cnt <= both_cnt + 1;
  end

  int rise2_cyc = 0, last_rise_cyc = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n periods of a wave with period p and high time h, rising at period start
  task automatic wave(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < p; i++) begin
        step();
        sig_in = (i < h);
        if (i == 0) begin
          last_rise_cyc = cyc;
          if (k == 1) rise2_cyc = cyc;
        end
      end
    end
  endtask

  int mv0, to0;

  initial begin
    // reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_period", period, 0);
    check("rst_high", high_time, 0);
    check("rst_mv", meas_valid, 0);
    check("rst_to", timeout, 0);
    check("rst_busy", busy, 0);
    step();
    reset = 1'b0;
    step();
    enable = 1'b1;
    @(negedge clk);
    check("busy_pre", busy, 0);
    step();
    check("busy_on", busy, 1);

    // square wave P=10 H=4: arming rise, then 3 results
    mark_cyc = cyc;
    mv0 = mv_cnt;
    wave(10, 4, 4);
    check("sq_count", mv_cnt - mv0, 3);
    check("sq_latency", first_mv_cyc - rise2_cyc, LAT);
    check("sq_period", period, 10);
    check("sq_high", high_time, 4);
    check("sq_gap", last_gap, 10);

    // duty change to P=7 H=3, back-to-back
    wave(7, 3, 4);
    check("dc_period", period, 7);
    check("dc_high", high_time, 3);
    check("dc_gap", last_gap, 7);

    // stall low: exactly one timeout, results unchanged, back to ARM
    mv0 = mv_cnt;
    to0 = to_cnt;
    repeat (30) step();
    check("to_count", to_cnt - to0, 1);
    check("to_time", to_cyc - last_rise_cyc, LAT + TMAX);
    check("to_no_mv", mv_cnt - mv0, 0);
    check("to_period", period, 7);
    check("to_high", high_time, 3);
    check("to_busy", busy, 1);

    // resume from ARM: first rise only arms
    mark_cyc = cyc;
    mv0 = mv_cnt;
    wave(10, 4, 3);
    check("rs_count", mv_cnt - mv0, 2);
    check("rs_latency", first_mv_cyc - rise2_cyc, LAT);
    check("rs_period", period, 10);

    // boundary: P equals TIMEOUT_MAX is a measurement, not a timeout
    to0 = to_cnt;
    wave(20, 5, 3);
    check("bd_period", period, 20);
    check("bd_high", high_time, 5);
    check("bd_gap", last_gap, 20);
    check("bd_no_to", to_cnt - to0, 0);

    // enable drop mid-interval
    wave(10, 4, 2);
    check("en_pre_period", period, 10);
    check("en_pre_high", high_time, 4);
    check("en_first_after_bd", to_cnt - to0, 0);
    mv0 = mv_cnt;
    to0 = to_cnt;
    enable = 1'b0;
    @(negedge clk);
    check("en_busy_hold", busy, 1);
    step();
    check("en_busy_off", busy, 0);
    wave(10, 4, 2);
    check("en_no_mv", mv_cnt - mv0, 0);
    check("en_no_to", to_cnt - to0, 0);
    check("en_period", period, 10);
    check("en_high", high_time, 4);

    // async reset mid-interval
    enable = 1'b1;
    wave(7, 2, 3);
    check("pre_rst_period", period, 7);
    for (int i = 0; i < 4; i++) begin
      step();
      sig_in = (i < 2);
    end
    #3;
    reset = 1'b1;
    #1;
    check("ar_period", period, 0);
    check("ar_high", high_time, 0);
    check("ar_mv", meas_valid, 0);
    check("ar_to", timeout, 0);
    check("ar_busy", busy, 0);
    sig_in = 1'b0;
    repeat (2) step();
    #3;
    reset = 1'b0;
    mark_cyc = cyc;
    mv0 = mv_cnt;
    wave(10, 4, 3);
    check("ar_count", mv_cnt - mv0, 2);
    check("ar_latency", first_mv_cyc - rise2_cyc, LAT);
    check("ar_res_period", period, 10);
    check("ar_res_high", high_time, 4);

    check("mv_to_overlap", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // hard bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
